// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clamped parallel load.
// The terminal-count output is combinational so that stages can be cascaded.
// Each stage's wrap pulse and sticky overflow flag are registered.
module mod_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // The top count value. It is expressed in WIDTH bits so that MODULUS == 2**WIDTH also fits.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nextQ;
  logic [WIDTH-1:0] loadVal;

  // Terminal count: the next enabled step in the current direction will wrap around.
  assign tc = en & ~load & (up ? (q == LAST) : (q == '0));

  // Out-of-range load values are clamped to the top count, so q never leaves 0..MODULUS-1.
  assign loadVal = (din > LAST) ? LAST : din;

  // Next count value, using the priority load, then enabled step, then hold.
  always_comb begin
    nextQ = q;
    if (load) begin
      nextQ = loadVal;
    end else if (en) begin
      if (up) begin
        nextQ = (q == LAST) ? '0 : q + WIDTH'(1);
      end else begin
        nextQ = (q == '0) ? LAST : q - WIDTH'(1);
      end
    end
  end

  // Count register. clr aborts any step immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else begin
      q <= nextQ;
    end
  end

  // The wrap pulse follows each terminal-count edge. In ovf, a set has priority over a clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= tc;
      ovf  <= tc | (ovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter.
// A modulo-10 and a modulo-16 instance share their stimulus and are compared against an arithmetic reference model.
// A separate two-digit cascade counts from 00 to 99.
module tb_mod_updown_counter;

  logic       clk;
  logic       clr;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;
  logic       ovfClr;

  logic [3:0] q10, q16;
  logic       tc10, tc16, wrap10, wrap16, ovf10, ovf16;

  logic       cascClr;
  logic [3:0] cq0, cq1;
  logic       ctc0, ctc1, cwrap0, cwrap1, covf0, covf1;

  int checks   = 0;
  int failures = 0;

  // Reference model state, indexed by 0 for the modulo-10 instance and 1 for the modulo-16 instance.
  int modArr[2] = '{10, 16};
  int mQ[2];
  bit mW[2];
  bit mO[2];

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
    .ovf_clr(ovfClr), .q(q10), .tc(tc10), .wrap(wrap10), .ovf(ovf10)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
    .ovf_clr(ovfClr), .q(q16), .tc(tc16), .wrap(wrap16), .ovf(ovf16)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) casc0 (
    .clk(clk), .clr(cascClr), .en(1'b1), .up(1'b1), .load(1'b0), .din(4'd0),
    .ovf_clr(1'b0), .q(cq0), .tc(ctc0), .wrap(cwrap0), .ovf(covf0)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) casc1 (
    .clk(clk), .clr(cascClr), .en(ctc0), .up(1'b1), .load(1'b0), .din(4'd0),
    .ovf_clr(1'b0), .q(cq1), .tc(ctc1), .wrap(cwrap1), .ovf(covf1)
  );

  // Free-running clock with a period of 10 time units.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Terminal count: an enabled, non-load step would leave the range 0..M-1.
  function automatic bit modelTc(int k);
    int nxt;
    nxt = mQ[k] + (up ? 1 : -1);
    return en && !load && (nxt < 0 || nxt >= modArr[k]);
  endfunction

  // Advances the reference model by one clock edge.
  task automatic modelStep(int k);
    bit t;
    t = modelTc(k);
    if (load) mQ[k] = (int'(din) < modArr[k]) ? int'(din) : modArr[k] - 1;
    else if (en) mQ[k] = (mQ[k] + (up ? 1 : -1) + modArr[k]) % modArr[k];
    mW[k] = t;
    mO[k] = t || (mO[k] && !ovfClr);
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mQ[k] = 0;
      mW[k] = 1'b0;
      mO[k] = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkRegs();
    checkOutput("q10", q10, mQ[0]);
    checkOutput("wrap10", wrap10, mW[0]);
    checkOutput("ovf10", ovf10, mO[0]);
    checkOutput("q16", q16, mQ[1]);
    checkOutput("wrap16", wrap16, mW[1]);
    checkOutput("ovf16", ovf16, mO[1]);
  endtask

  // Drives one cycle of inputs, checks tc combinationally, then checks the registers after the edge.
  task automatic applyStimulus(input bit e, input bit u, input bit l, input logic [3:0] d, input bit oc);
    en = e; up = u; load = l; din = d; ovfClr = oc;
    #1;
    checkOutput("tc10", tc10, modelTc(0));
    checkOutput("tc16", tc16, modelTc(1));
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkRegs();
  endtask

  initial begin
    clr = 1'b1; cascClr = 1'b1;
    en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0; ovfClr = 1'b0;
    modelReset();

    // Reset state
    #12;
    checkOutput("rstQ", q10, 0);
    checkOutput("rstWrap", wrap10, 0);
    checkOutput("rstOvf", ovf10, 0);
    checkOutput("rstTc", tc10, 0);
    @(posedge clk); #1;
    clr = 1'b0;

    // Count up for 12 edges: 1..9, 0, 1, 2
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, 0, 4'd0, 0);
    checkOutput("upEndQ", q10, 2);
    checkOutput("upEndOvf", ovf10, 1);

    // Clear the sticky flag
    applyStimulus(0, 1, 0, 4'd0, 1);
    checkOutput("ovfCleared", ovf10, 0);

    // Clamped load, then an in-range load
    applyStimulus(1, 1, 1, 4'd13, 0);
    checkOutput("clampQ", q10, 9);
    checkOutput("clampWrap", wrap10, 0);
    applyStimulus(1, 1, 1, 4'd5, 0);
    checkOutput("loadQ", q10, 5);

    // Count down from 0: 9, 8, 7
    applyStimulus(0, 0, 1, 4'd0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 4'd0, 0);
    checkOutput("downQ", q10, 7);

    // Wrap from 9 together with ovf_clr: set wins
    applyStimulus(0, 1, 1, 4'd9, 1);
    applyStimulus(1, 1, 0, 4'd0, 1);
    checkOutput("setWinsQ", q10, 0);
    checkOutput("setWinsWrap", wrap10, 1);
    checkOutput("setWinsOvf", ovf10, 1);
    applyStimulus(0, 1, 0, 4'd0, 1);
    checkOutput("ovfClrAfter", ovf10, 0);

    // Randomized phase, with loads kept rare
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 5) == 0);
    end

    // Asynchronous clear in the middle of counting
    applyStimulus(1, 1, 1, 4'd6, 0);
    applyStimulus(1, 1, 0, 4'd0, 0);
    en = 1'b1; up = 1'b1; load = 1'b0; ovfClr = 1'b0;
    #2 clr = 1'b1;
    #1;
    checkOutput("asyncQ", q10, 0);
    checkOutput("asyncWrap", wrap10, 0);
    checkOutput("asyncOvf", ovf10, 0);
    checkOutput("clrTcUp", tc10, 0);
    up = 1'b0;
    #1;
    checkOutput("clrTcDown", tc10, 1);
    @(posedge clk); #1;
    checkOutput("clrHoldQ", q10, 0);
    clr = 1'b0;
    modelReset();
    applyStimulus(1, 1, 0, 4'd0, 0);
    checkOutput("postClrQ", q10, 1);

    // Two-digit cascade counting from 00 through 99 and back to 00
    cascClr = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      checkOutput("cascade", int'(cq1) * 10 + int'(cq0), i % 100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, meaning the count register width in bits.
REQ-002 The module SHALL have parameter MODULUS, default 16, meaning the number of count states (0 .. MODULUS-1); legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 The module SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 The module SHALL have port clr, input, 1, reset: asynchronous, active-high.
REQ-005 The module SHALL have port en, input, 1, count enable.
REQ-006 The module SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-007 The module SHALL have port load, input, 1, synchronous parallel load strobe.
REQ-008 The module SHALL have port din, input, WIDTH, parallel load value.
REQ-009 The module SHALL have port ovf_clr, input, 1, synchronous clear of sticky overflow flag.
REQ-010 The module SHALL have port q, output, WIDTH, registered count value.
REQ-011 The module SHALL have port tc, output, 1, combinational terminal count, for cascading.
REQ-012 The module SHALL have port wrap, output, 1, registered one-cycle wrap pulse.
REQ-013 The module SHALL have port ovf, output, 1, registered sticky wrap flag.

Function
REQ-014 All state SHALL update only on rising clk edge, except clr.
REQ-015 Per-edge priority SHALL be: load, then en, then hold.
REQ-016 load=1: q SHALL take din if din < MODULUS, else MODULUS-1 (clamp); wrap SHALL be 0 that cycle.
REQ-017 load=0, en=1, up=1: q SHALL become q+1, or 0 when q == MODULUS-1.
REQ-018 load=0, en=1, up=0: q SHALL become q-1, or MODULUS-1 when q == 0.
REQ-019 load=0, en=0: q SHALL hold; wrap SHALL be 0.
REQ-020 tc SHALL equal en & ~load & (up ? q == MODULUS-1 : q == 0), combinationally, no clock delay.
REQ-021 wrap SHALL be 1 for exactly the cycle after an edge at which tc was 1, else 0.
REQ-022 ovf SHALL set on any edge where tc=1 and hold until cleared.
REQ-023 ovf_clr=1 SHALL clear ovf at the next edge; simultaneous tc=1 and ovf_clr=1 SHALL leave ovf=1 (set wins).
REQ-024 Change of up SHALL take effect at the same edge it is sampled; no pipeline delay.
REQ-025 Count latency SHALL be one clock: q reflects an enabled step at the edge sampling en=1.
REQ-026 q SHALL never hold a value >= MODULUS in any state reachable without X inputs.
REQ-027 When MODULUS == 2**WIDTH, wrap-around SHALL follow natural binary overflow with identical tc/wrap behaviour.
REQ-028 Cascading: tc of stage N driving en of stage N+1, all on a shared clk, SHALL form a synchronous multi-digit counter without ripple delay.

Reset
REQ-029 clr=1 SHALL immediately, without clk, force q=0, wrap=0, ovf=0.
REQ-030 While clr=1, load, en and ovf_clr SHALL be ignored; tc SHALL follow REQ-020 using q=0.
REQ-031 clr asserted mid-count SHALL abort any step; the first edge after clr deassertion SHALL apply normal rules from q=0.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-032 clr pulse at t=3 during counting, clk free-running -> q=0, wrap=0, ovf=0 immediately, before next clk edge.
REQ-033 en=1, up=1, from q=0 for 12 edges -> q sequence 1..9,0,1,2; tc=1 while q=9; wrap=1 exactly one cycle when q becomes 0; ovf=1 thereafter.
REQ-034 en=1, up=0 from q=0 -> q=9,8,7; tc=1 at q=0 only; wrap pulses after the 0->9 transition.
REQ-035 load=1, en=1, din=4'd13 -> q=9 (clamped), wrap=0; then load=1, din=4'd5 -> q=5.
REQ-036 q=9, up=1, en=1, ovf_clr=1 at same edge -> q=0, wrap=1, ovf=1; next edge ovf_clr=1, en=0 -> ovf=0.
REQ-037 Two instances cascaded (tc0 -> en1), en0=1, up=1, 100 edges from 0 -> {q1,q0} counts 00..99 then 00; q1 steps on exactly the edge q0 goes 9->0.
